// File: rtl/phase_controller_if.sv
// phase_controller_if
// Groups the run-control, instruction and memory handshake signals of the
// phase controller into one bundle.
//   start, stop   : run request (taken in IDLE) / stop request (any cycle)
//   COMMAND       : current instruction word, valid from ID through WB
//   mem_ack       : memory completion, meaningful only while mem_req is high
//   phase         : one-hot phase enables {WB, MEM, EX, ID, IF}
//   mem_req       : memory request, high in IF and MEM
//   ir_load       : one-cycle instruction register load pulse
//   pc_inc        : one-cycle program counter increment pulse
//   running       : high in IF, ID, EX, MEM and WB
//   halted        : high in HALT
//   instr_count   : number of retired instructions
// The master modport is the side that drives requests (CPU datapath or bench);
// the slave modport is the controller itself.
interface phase_controller_if;
    logic        start;
    logic        stop;
    logic [15:0] COMMAND;
    logic        mem_ack;
    logic [4:0]  phase;
    logic        mem_req;
    logic        ir_load;
    logic        pc_inc;
    logic        running;
    logic        halted;
    logic [15:0] instr_count;

    modport master (
        output start, stop, COMMAND, mem_ack,
        input  phase, mem_req, ir_load, pc_inc, running, halted, instr_count
    );

    modport slave (
        input  start, stop, COMMAND, mem_ack,
        output phase, mem_req, ir_load, pc_inc, running, halted, instr_count
    );
endinterface

// File: rtl/phase_controller.sv
// phase_controller
// Sequences a simple CPU through IF, ID, EX, MEM and WB phases, waits on the
// memory handshake in IF and MEM, counts retired instructions and stops in
// HALT on an HLT instruction.
// Ports:
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset
//   bus   : phase_controller_if.slave, see the interface file for signals
// Every output is decoded from the state register or comes straight from a
// register, so there is no combinational path from inputs to outputs.
module phase_controller (
    input  logic               clk,
    input  logic               rst_n,
    phase_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  rst_sync;
    logic        run_en;
    logic        stop_pending;
    logic [15:0] count_q;
    logic        in_run;
    logic        is_hlt;
    logic        unused_cmd;

    // Only the opcode field and the HLT sub-field are decoded here.
    assign unused_cmd = ^{bus.COMMAND[13:8], bus.COMMAND[3:0]};

    // Reset release is pushed through two flops; IDLE refuses to leave until
    // the second flop is set, so a start can act on the third edge at the
    // earliest and reset removal never races the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run_en = rst_sync[1];

    assign is_hlt = (bus.COMMAND[15:14] == 2'b11) && (bus.COMMAND[7:4] == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and decoded outputs. ir_load/pc_inc are decoded from ID,
    // which always lasts exactly one cycle, giving the single-cycle pulse.
    // A stop arriving in the WB cycle itself is honoured immediately.
    always_comb begin
        state_d     = state_q;
        bus.phase   = 5'b00000;
        bus.mem_req = 1'b0;
        bus.ir_load = 1'b0;
        bus.pc_inc  = 1'b0;
        bus.running = 1'b0;
        bus.halted  = 1'b0;
        in_run      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_en && bus.start) begin
                    state_d = ST_IF;
                end
            end
            ST_IF: begin
                bus.phase   = 5'b00001;
                bus.mem_req = 1'b1;
                in_run      = 1'b1;
                if (bus.mem_ack) begin
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                bus.phase   = 5'b00010;
                bus.ir_load = 1'b1;
                bus.pc_inc  = 1'b1;
                in_run      = 1'b1;
                state_d     = is_hlt ? ST_HALT : ST_EX;
            end
            ST_EX: begin
                bus.phase = 5'b00100;
                in_run    = 1'b1;
                state_d   = (bus.COMMAND[15] == 1'b0) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                bus.phase   = 5'b01000;
                bus.mem_req = 1'b1;
                in_run      = 1'b1;
                if (bus.mem_ack) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                bus.phase = 5'b10000;
                in_run    = 1'b1;
                state_d   = (stop_pending || bus.stop) ? ST_IDLE : ST_IF;
            end
            ST_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        bus.running = in_run;
    end

    // The stop flag remembers a stop seen in any running phase until the
    // instruction boundary; entering (or sitting in) IDLE clears it, so stops
    // in IDLE are dropped. HALT leaves it untouched since only reset exits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_pending <= 1'b0;
        end else if (state_d == ST_IDLE) begin
            stop_pending <= 1'b0;
        end else if (in_run && bus.stop) begin
            stop_pending <= 1'b1;
        end
    end

    // Retire count advances once per WB and wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'h0000;
        end else if (state_q == ST_WB) begin
            count_q <= count_q + 16'h0001;
        end
    end

    assign bus.instr_count = count_q;

endmodule

// File: doc/phase_controller.md
PHASE_CONTROLLER -- requirements
Module: phase_controller

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 stop  input  1  stop request; any-cycle pulse, honoured at the next instruction boundary.
REQ-006 COMMAND  input  16  current instruction word, valid from ID through WB.
REQ-007 mem_ack  input  1  memory completion; valid only while mem_req=1.
REQ-008 phase  output  5  one-hot phase enables: bit0 IF, bit1 ID, bit2 EX, bit3 MEM, bit4 WB; all zero in IDLE/HALT.
REQ-009 mem_req  output  1  memory request; high throughout IF and MEM until acknowledged.
REQ-010 ir_load  output  1  one-cycle pulse that loads the instruction register.
REQ-011 pc_inc  output  1  one-cycle pulse that increments the program counter.
REQ-012 running  output  1  high in IF, ID, EX, MEM and WB.
REQ-013 halted  output  1  high in HALT.
REQ-014 instr_count  output  16  number of retired instructions.

Function
REQ-015 States SHALL be IDLE, IF, ID, EX, MEM, WB and HALT; every output is registered or decoded from the state register only, with no combinational path from inputs to outputs.
REQ-016 IDLE: start=1 -> IF next cycle; otherwise stay in IDLE.
REQ-017 IF: mem_req=1; mem_ack=1 -> ID, with ir_load and pc_inc pulsed high for exactly the cycle in which ID is entered; mem_ack=0 -> stay in IF (unbounded wait).
REQ-018 ID: if COMMAND[15:14]=11 and COMMAND[7:4]=1111 (HLT) -> HALT; otherwise -> EX.
REQ-019 EX: if COMMAND[15:14]=00 (LD) or 01 (ST) -> MEM; otherwise -> WB.
REQ-020 MEM: mem_req=1; mem_ack=1 -> WB; otherwise stay in MEM.
REQ-021 WB: instr_count increments by 1, wrapping modulo 2^16 (FFFF -> 0000); then -> IDLE if stop_pending=1, else -> IF.
REQ-022 stop_pending SHALL be an internal flag set by stop=1 in any running state and cleared on entry to IDLE; stop in IDLE or HALT is ignored.
REQ-023 If stop and the WB->IDLE decision occur in the same cycle, the stop SHALL be honoured in that same cycle.
REQ-024 HALT SHALL be left only by reset; start and stop are ignored; instr_count is held, and HLT is not counted.
REQ-025 mem_ack outside IF and MEM SHALL be ignored.
REQ-026 mem_req SHALL fall in the cycle after the acknowledging edge, because the state has advanced.
REQ-027 start while running SHALL be ignored.
REQ-028 Minimum latency per instruction SHALL be 4 cycles for a non-memory instruction with single-cycle ack (IF, ID, EX, WB) and 5 cycles for LD/ST.

Reset
REQ-029 rst_n=0 SHALL immediately force: state=IDLE, phase=00000, mem_req=0, ir_load=0, pc_inc=0, running=0, halted=0, instr_count=0000, stop_pending=0.
REQ-030 Reset asserted mid-instruction, including during a pending mem_req, SHALL abandon the access with no completion pulse; after release the block waits in IDLE for start.
REQ-031 Reset release SHALL be synchronised so that the first state change occurs no earlier than the second rising clk edge after rst_n rises.

Verification
REQ-032 Run of ADD: start pulse, COMMAND=C000, mem_ack tied 1 -> phase sequence 00001, 00010, 00100, 10000, 00001 repeats; instr_count increments once every 4 cycles.
REQ-033 LD with wait states: COMMAND=0000, mem_ack low for 3 cycles in IF and 2 in MEM -> IF lasts 4 cycles, MEM lasts 3; ir_load pulses once; instr_count +1 after 10 cycles.
REQ-034 HLT: COMMAND=C0F0 after one ADD -> ID then HALT, halted=1, instr_count=0001, phase=00000; a later start pulse causes no change.
REQ-035 Stop: stop pulse during EX of an ADD -> WB completes, then IDLE with instr_count+1; a subsequent start resumes in IF.
REQ-036 Wrap: preload to FFFF by running 65535 ADDs (or force), then retire one more instruction -> instr_count=0000 with no other effect.
REQ-037 Reset during MEM with mem_req=1 -> all outputs at reset values asynchronously; after release the block stays in IDLE with mem_req=0 until start.
